// File: rtl/score_scan_controller_if.sv
// Scoreboard bus: hit/clear inputs, shared decoder loop (W_OUT -> SEG_IN), HEX and score outputs.
interface score_scan_controller_if;
    logic       HIT1;
    logic       HIT2;
    logic       CLR;
    logic [1:7] SEG_IN;
    logic [3:0] W_OUT;
    logic [1:7] HEX0;
    logic [1:7] HEX1;
    logic [1:7] HEX2;
    logic [1:7] HEX3;
    logic [7:0] SCORE1;
    logic [7:0] SCORE2;

    modport master (
        output HIT1, HIT2, CLR, SEG_IN,
        input  W_OUT, HEX0, HEX1, HEX2, HEX3, SCORE1, SCORE2
    );

    modport slave (
        input  HIT1, HIT2, CLR, SEG_IN,
        output W_OUT, HEX0, HEX1, HEX2, HEX3, SCORE1, SCORE2
    );
endinterface

// File: rtl/score_scan_controller.sv
// Two saturating BCD scores scanned through one shared 7-segment decoder into HEX0-HEX3.
// Optional SCORE_LEADING_ZERO_BLANK_EN blanks a zero tens digit on HEX1/HEX3.
module score_scan_controller #(
    parameter int unsigned SCAN_DIV = 4
) (
    input logic                    CLOCK,
    input logic                    RESET,
    score_scan_controller_if.slave bus
);

    localparam logic [7:0] DwellLast = 8'(SCAN_DIV - 1);
    localparam logic [1:7] SegBlank  = 7'b1111111;

    typedef enum logic [1:0] {S0, S1, S2, S3} slot_e;

    slot_e      slot_q, slot_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] score1_q, score1_d;
    logic [7:0] score2_q, score2_d;
    logic [1:7] hex0_q, hex0_d;
    logic [1:7] hex1_q, hex1_d;
    logic [1:7] hex2_q, hex2_d;
    logic [1:7] hex3_q, hex3_d;
    logic [3:0] w_digit;
    logic [1:7] cap_seg;
    logic       last_dwell;

    // Saturates at 99; ones digit 9 carries into tens.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s == 8'h99) begin
            r = s;
        end else if (s[3:0] == 4'd9) begin
            r = {s[7:4] + 4'd1, 4'd0};
        end else begin
            r = {s[7:4], s[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        score1_d = score1_q;
        score2_d = score2_q;
        if (bus.CLR) begin
            score1_d = 8'h00;
            score2_d = 8'h00;
        end else begin
            if (bus.HIT1) score1_d = bcd_inc(score1_q);
            if (bus.HIT2) score2_d = bcd_inc(score2_q);
        end
    end

    always_comb begin
        w_digit = 4'd0;
        unique case (slot_q)
            S0: w_digit = score1_q[3:0];
            S1: w_digit = score1_q[7:4];
            S2: w_digit = score2_q[3:0];
            S3: w_digit = score2_q[7:4];
            default: w_digit = 4'd0;
        endcase
    end

    always_comb begin
        cap_seg = bus.SEG_IN;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if ((slot_q == S1 || slot_q == S3) && w_digit == 4'd0) cap_seg = SegBlank;
`endif
    end

    assign last_dwell = (dwell_q == DwellLast);

    always_comb begin
        slot_d  = slot_q;
        dwell_d = dwell_q + 8'd1;
        hex0_d  = hex0_q;
        hex1_d  = hex1_q;
        hex2_d  = hex2_q;
        hex3_d  = hex3_q;
        if (last_dwell) begin
            dwell_d = 8'd0;
            unique case (slot_q)
                S0: begin hex0_d = cap_seg; slot_d = S1; end
                S1: begin hex1_d = cap_seg; slot_d = S2; end
                S2: begin hex2_d = cap_seg; slot_d = S3; end
                S3: begin hex3_d = cap_seg; slot_d = S0; end
                default: slot_d = S0;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            slot_q   <= S0;
            dwell_q  <= 8'd0;
            score1_q <= 8'h00;
            score2_q <= 8'h00;
            hex0_q   <= SegBlank;
            hex1_q   <= SegBlank;
            hex2_q   <= SegBlank;
            hex3_q   <= SegBlank;
        end else begin
            slot_q   <= slot_d;
            dwell_q  <= dwell_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            hex0_q   <= hex0_d;
            hex1_q   <= hex1_d;
            hex2_q   <= hex2_d;
            hex3_q   <= hex3_d;
        end
    end

    assign bus.W_OUT  = w_digit;
    assign bus.HEX0   = hex0_q;
    assign bus.HEX1   = hex1_q;
    assign bus.HEX2   = hex2_q;
    assign bus.HEX3   = hex3_q;
    assign bus.SCORE1 = score1_q;
    assign bus.SCORE2 = score2_q;

endmodule

// File: doc/score_scan_controller.md
# score_scan_controller

Sequences the shared single-digit 7-segment decoder for the Dance Dance Revolution scoreboard. It keeps two 2-digit BCD player scores, which increment on hit pulses and saturate at 99. It time-multiplexes the four score digits through one external decoder (4-bit digit in, active-low `[1:7]` segments out) and latches each decoded pattern into a per-digit register that drives HEX0–HEX3.

## Interface
Parameters:
- `SCAN_DIV`, default 4: clock cycles each digit slot owns the decoder. Legal range is 1–255.

Ports:
- `CLOCK` in 1: system clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `HIT1` in 1: player 1 scoring pulse, one cycle per hit.
- `HIT2` in 1: player 2 scoring pulse, one cycle per hit.
- `CLR` in 1: synchronous clear of both scores.
- `SEG_IN` in 7, `[1:7]`: decoder segment output for `W_OUT`, active-low, combinational from `W_OUT`.
- `W_OUT` out 4: digit currently presented to the decoder.
- `HEX0`, `HEX1`, `HEX2`, `HEX3` out 7 each, `[1:7]`: registered active-low segment patterns.
- `SCORE1` out 8: player 1 score in BCD, `{tens, ones}`.
- `SCORE2` out 8: player 2 score in BCD, `{tens, ones}`.

## Operation
- **Score update**, per player, each rising edge:
  - `CLR` = 1 → score becomes 8'h00. `CLR` has priority over a hit in the same cycle.
  - Otherwise, hit = 1 and score < 8'h99 → BCD increment. When ones = 9, ones becomes 0 and tens increments.
  - Otherwise → hold. At 8'h99 the score saturates and does not wrap.
- Both players update independently. `HIT1` and `HIT2` asserted in the same cycle both take effect.
- **Scan state machine:** 2-bit slot counter (S0–S3) plus an 8-bit dwell counter (0 to `SCAN_DIV`−1).
  - S0 → P1 ones → HEX0
  - S1 → P1 tens → HEX1
  - S2 → P2 ones → HEX2
  - S3 → P2 tens → HEX3
  - Transitions run S0→S1→S2→S3→S0 unconditionally.
- `W_OUT` is a combinational mux of the current slot and the score registers. It always reflects the current score digit.
- On the last dwell cycle of a slot (dwell = `SCAN_DIV`−1), at the clock edge:
  - `SEG_IN` is captured into that slot's HEX register.
  - The dwell counter clears and the slot advances.
- `W_OUT` is never outside 0–9. Decoder outputs for 10–15 therefore never matter.
- **Reset** (asynchronous, immediate on `RESET`):
  - Scores = 8'h00.
  - Slot = S0, dwell = 0, so `W_OUT` = 0.
  - HEX0–HEX3 = 7'b1111111 (all segments off).
- **Reset released mid-scan:** scanning restarts at S0. HEX registers stay blank until each slot's first capture.

## Timing
- Hit-to-`SCORE` latency: 1 cycle. A score change is visible on `SCOREn` after the edge that samples the hit.
- Hit-to-HEX latency:
  - Worst case 4·`SCAN_DIV` cycles plus 1 edge.
  - Best case 1 edge, when the hit's update lands exactly as the owning slot is on its last dwell cycle.
- Full refresh period: 4·`SCAN_DIV` cycles.
- First complete display after reset: all four HEX registers are valid after 4·`SCAN_DIV` edges.
- `SEG_IN` must settle within one cycle of `W_OUT` changing. It is sampled only on last-dwell edges.
- A score change during a slot's dwell: the capture uses the digit value in the capture cycle. No tearing occurs within a digit.

## Configuration
- Macro: `SCORE_LEADING_ZERO_BLANK_EN`.
- **Defined:** in S1 or S3, if the tens digit is 0, HEX1/HEX3 capture 7'b1111111 instead of `SEG_IN`. A score of 7 displays as blank + "7".
- **Undefined:** all slots capture `SEG_IN` unconditionally. A score of 7 displays "07" (HEX1 = 7'b0000001).
- Score arithmetic, `W_OUT` and timing are identical in both builds.

## Test plan
Bench uses `SCAN_DIV` = 2 with a behavioural decoder model on `SEG_IN`.
- **Reset:** assert `RESET` mid-scan.
  - → `SCORE1` = `SCORE2` = 8'h00, `W_OUT` = 0, HEX0–HEX3 = 7'b1111111 without a clock edge.
  - → After 8 edges: HEX0 = HEX2 = 7'b0000001.
- **Carry:** 10 `HIT1` pulses.
  - → `SCORE1` = 8'h10.
  - → After 8 more edges: HEX1 = 7'b1001111, HEX0 = 7'b0000001.
- **Saturation:** 105 `HIT2` pulses.
  - → `SCORE2` = 8'h99 and stays there.
  - → HEX3 = HEX2 = 7'b0000100.
- **Simultaneous events:**
  - `HIT1` + `HIT2` in one cycle from 8'h41/8'h09 → 8'h42/8'h10.
  - `CLR` + `HIT1` in one cycle → `SCORE1` = 8'h00.
- **Scan order:** monitor `W_OUT` with `SCORE1` = 8'h35, `SCORE2` = 8'h72.
  - → Sequence 5,5,3,3,2,2,7,7 repeating.
  - → HEX captures occur on every second edge.
- **Macro:** `SCORE1` = 8'h07.
  - → With `SCORE_LEADING_ZERO_BLANK_EN` defined: HEX1 = 7'b1111111.
  - → With it undefined: HEX1 = 7'b0000001.
